// File: rtl/multicycle_control_fsm.sv
// Main sequencing controller for the multi-cycle MIPS datapath.
// Moore decode per state, with mem_ready gating in FETCH/MEM_READ/MEM_WRITE and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int COUNT_W       = 32,
  parameter int FETCH_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               zero_ext,
  output logic [1:0]         pc_source,
  output logic [2:0]         alu_op,
  output logic [3:0]         state,
  output logic               illegal_op,
  output logic               instr_retired,
  output logic [COUNT_W-1:0] retired_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  if (FETCH_TIMEOUT != 0) begin : g_bad_timeout
    $error("FETCH_TIMEOUT is reserved and must be 0");
  end

  // Branch condition is resolved in the datapath (pc_write_cond AND zero).
  logic unused_zero;
  assign unused_zero = zero;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    zero_ext      = 1'b0;
    pc_source     = 2'b00;
    alu_op        = 3'b000;
    illegal_op    = 1'b0;
    instr_retired = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_RTYPE:                          state_d = S_R_EXEC;
          OP_BEQ:                            state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write     = 1'b1;
        mem_to_reg    = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEM_WRITE: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write     = 1'b1;
        reg_dst       = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write      = 1'b1;
        pc_source     = 2'b10;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ANDI: begin
            alu_op   = 3'b101;
            zero_ext = 1'b1;
          end
          OP_ORI: begin
            alu_op   = 3'b011;
            zero_ext = 1'b1;
          end
          OP_SLTI: alu_op = 3'b100;
          default: alu_op = 3'b000;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
        state_d       = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset kills all side effects and presents the FETCH select pattern.
    if (reset) begin
      state_d       = S_FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b01;
      zero_ext      = 1'b0;
      pc_source     = 2'b00;
      alu_op        = 3'b000;
      illegal_op    = 1'b0;
      instr_retired = 1'b0;
    end

    count_d = count_q + {{(COUNT_W-1){1'b0}}, instr_retired};
  end

  assign state         = state_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table-driven bench for multicycle_control_fsm: per-cycle inputs with hand-computed state,
// control word and retired count, plus a hand-written reset-abort sequence.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext;
  logic [1:0]  alu_src_b, pc_source;
  logic [2:0]  alu_op;
  logic [3:0]  state;
  logic        illegal_op, instr_retired;
  logic [31:0] retired_count;
  logic        s_pc_write, s_pc_write_cond, s_i_or_d, s_mem_read, s_mem_write, s_ir_write;
  logic        s_mem_to_reg, s_reg_dst, s_reg_write, s_alu_src_a, s_zero_ext;
  logic [1:0]  s_alu_src_b, s_pc_source;
  logic [2:0]  s_alu_op;
  logic [3:0]  s_state;
  logic        s_illegal_op, s_instr_retired;
  logic [2:0]  s_count;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.COUNT_W(32), .FETCH_TIMEOUT(0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext),
    .pc_source(pc_source), .alu_op(alu_op), .state(state),
    .illegal_op(illegal_op), .instr_retired(instr_retired), .retired_count(retired_count)
  );

  // Narrow counter instance shows modulo wrap within a short run.
  multicycle_control_fsm #(.COUNT_W(3), .FETCH_TIMEOUT(0)) dut_small (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(s_pc_write), .pc_write_cond(s_pc_write_cond), .i_or_d(s_i_or_d),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .ir_write(s_ir_write),
    .mem_to_reg(s_mem_to_reg), .reg_dst(s_reg_dst), .reg_write(s_reg_write),
    .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .zero_ext(s_zero_ext),
    .pc_source(s_pc_source), .alu_op(s_alu_op), .state(s_state),
    .illegal_op(s_illegal_op), .instr_retired(s_instr_retired), .retired_count(s_count)
  );

  logic [19:0] act_cw;
  assign act_cw = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, zero_ext,
                   pc_source, alu_op, illegal_op, instr_retired};

  function automatic logic [19:0] cw(
    input logic pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa,
    input logic [1:0] asb, input logic zx, input logic [1:0] psrc,
    input logic [2:0] aop, input logic ill, ret);
    return {pw, pwc, iod, mr, mw, irw, m2r, rdst, rw, asa, asb, zx, psrc, aop, ill, ret};
  endfunction

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        z;
    logic        rdy;
    logic [3:0]  exp_state;
    logic [19:0] exp_cw;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input logic r, input logic [5:0] o, input logic z_i, input logic rd,
                     input logic [3:0] st, input logic [19:0] c, input logic [31:0] n);
    vec_t v;
    v.rst = r; v.op = o; v.z = z_i; v.rdy = rd;
    v.exp_state = st; v.exp_cw = c; v.exp_cnt = n;
    vecs.push_back(v);
  endtask

  initial begin
    logic [19:0] RST, F_RDY, F_WAIT, DEC, DEC_ILL, MADDR, MREAD, MWB, MWR_W, MWR_R;
    logic [19:0] REXE, RWB, BR, JMP, I_ADD, I_AND, I_OR, I_SLT, IWB;
    logic [5:0]  op_i;
    int          n;

    //           pw pwc iod mr mw irw m2r rdst rw asa asb   zx psrc   aop    ill ret
    RST     = cw(0, 0,  0,  0, 0, 0,  0,  0,   0, 0, 2'b01, 0, 2'b00, 3'b000, 0, 0);
    F_RDY   = cw(1, 0,  0,  1, 0, 1,  0,  0,   0, 0, 2'b01, 0, 2'b00, 3'b000, 0, 0);
    F_WAIT  = cw(0, 0,  0,  1, 0, 0,  0,  0,   0, 0, 2'b01, 0, 2'b00, 3'b000, 0, 0);
    DEC     = cw(0, 0,  0,  0, 0, 0,  0,  0,   0, 0, 2'b11, 0, 2'b00, 3'b000, 0, 0);
    DEC_ILL = cw(0, 0,  0,  0, 0, 0,  0,  0,   0, 0, 2'b11, 0, 2'b00, 3'b000, 1, 0);
    MADDR   = cw(0, 0,  0,  0, 0, 0,  0,  0,   0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0);
    MREAD   = cw(0, 0,  1,  1, 0, 0,  0,  0,   0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0);
    MWB     = cw(0, 0,  0,  0, 0, 0,  1,  0,   1, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1);
    MWR_W   = cw(0, 0,  1,  0, 1, 0,  0,  0,   0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0);
    MWR_R   = cw(0, 0,  1,  0, 1, 0,  0,  0,   0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1);
    REXE    = cw(0, 0,  0,  0, 0, 0,  0,  0,   0, 1, 2'b00, 0, 2'b00, 3'b010, 0, 0);
    RWB     = cw(0, 0,  0,  0, 0, 0,  0,  1,   1, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1);
    BR      = cw(0, 1,  0,  0, 0, 0,  0,  0,   0, 1, 2'b00, 0, 2'b01, 3'b001, 0, 1);
    JMP     = cw(1, 0,  0,  0, 0, 0,  0,  0,   0, 0, 2'b00, 0, 2'b10, 3'b000, 0, 1);
    I_ADD   = cw(0, 0,  0,  0, 0, 0,  0,  0,   0, 1, 2'b10, 0, 2'b00, 3'b000, 0, 0);
    I_AND   = cw(0, 0,  0,  0, 0, 0,  0,  0,   0, 1, 2'b10, 1, 2'b00, 3'b101, 0, 0);
    I_OR    = cw(0, 0,  0,  0, 0, 0,  0,  0,   0, 1, 2'b10, 1, 2'b00, 3'b011, 0, 0);
    I_SLT   = cw(0, 0,  0,  0, 0, 0,  0,  0,   0, 1, 2'b10, 0, 2'b00, 3'b100, 0, 0);
    IWB     = cw(0, 0,  0,  0, 0, 0,  0,  0,   1, 0, 2'b00, 0, 2'b00, 3'b000, 0, 1);

    // reset held 3 cycles with mem_ready high
    for (int i = 0; i < 3; i++) add(1, 6'b000000, 0, 1, 4'd0, RST, 0);
    // R-type
    add(0, 6'b000000, 0, 1, 4'd0, F_RDY, 0);
    add(0, 6'b000000, 0, 1, 4'd1, DEC,   0);
    add(0, 6'b000000, 0, 1, 4'd6, REXE,  0);
    add(0, 6'b000000, 0, 1, 4'd7, RWB,   0);
    // lw with two wait cycles in MEM_READ
    add(0, 6'b100011, 0, 1, 4'd0, F_RDY, 1);
    add(0, 6'b100011, 0, 1, 4'd1, DEC,   1);
    add(0, 6'b100011, 0, 1, 4'd2, MADDR, 1);
    add(0, 6'b100011, 0, 0, 4'd3, MREAD, 1);
    add(0, 6'b100011, 0, 0, 4'd3, MREAD, 1);
    add(0, 6'b100011, 0, 1, 4'd3, MREAD, 1);
    add(0, 6'b100011, 0, 1, 4'd4, MWB,   1);
    // sw with a fetch stall and one write wait
    add(0, 6'b101011, 0, 0, 4'd0, F_WAIT, 2);
    add(0, 6'b101011, 0, 1, 4'd0, F_RDY,  2);
    add(0, 6'b101011, 0, 0, 4'd1, DEC,    2);
    add(0, 6'b101011, 0, 0, 4'd2, MADDR,  2);
    add(0, 6'b101011, 0, 0, 4'd5, MWR_W,  2);
    add(0, 6'b101011, 0, 1, 4'd5, MWR_R,  2);
    // beq taken then not taken; both retire
    add(0, 6'b000100, 1, 1, 4'd0, F_RDY, 3);
    add(0, 6'b000100, 1, 1, 4'd1, DEC,   3);
    add(0, 6'b000100, 1, 1, 4'd8, BR,    3);
    add(0, 6'b000100, 0, 1, 4'd0, F_RDY, 4);
    add(0, 6'b000100, 0, 1, 4'd1, DEC,   4);
    add(0, 6'b000100, 0, 0, 4'd8, BR,    4);
    // jump
    add(0, 6'b000010, 0, 1, 4'd0, F_RDY, 5);
    add(0, 6'b000010, 0, 1, 4'd1, DEC,   5);
    add(0, 6'b000010, 0, 0, 4'd9, JMP,   5);
    // andi, ori, slti, addi
    n = 6;
    for (int k = 0; k < 4; k++) begin
      logic [19:0] iexe;
      case (k)
        0: begin op_i = 6'b001100; iexe = I_AND; end
        1: begin op_i = 6'b001101; iexe = I_OR;  end
        2: begin op_i = 6'b001010; iexe = I_SLT; end
        default: begin op_i = 6'b001000; iexe = I_ADD; end
      endcase
      add(0, op_i, 0, 1, 4'd0,  F_RDY, n);
      add(0, op_i, 0, 1, 4'd1,  DEC,   n);
      add(0, op_i, 0, 1, 4'd10, iexe,  n);
      add(0, op_i, 0, 1, 4'd11, IWB,   n);
      n++;
    end
    // illegal opcode: pulse, back to FETCH, count unchanged
    add(0, 6'b111111, 0, 1, 4'd0, F_RDY,   10);
    add(0, 6'b111111, 0, 1, 4'd1, DEC_ILL, 10);
    add(0, 6'b101011, 0, 1, 4'd0, F_RDY,   10);

    reset = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; opcode = vecs[i].op; zero = vecs[i].z; mem_ready = vecs[i].rdy;
      #1;
      check($sformatf("state[%0d]", i), {28'd0, state}, {28'd0, vecs[i].exp_state});
      check($sformatf("ctrl[%0d]", i), {12'd0, act_cw}, {12'd0, vecs[i].exp_cw});
      check($sformatf("count[%0d]", i), retired_count, vecs[i].exp_cnt);
      check($sformatf("count3[%0d]", i), {29'd0, s_count}, {29'd0, vecs[i].exp_cnt[2:0]});
    end

    // sw aborted by reset while waiting in MEM_WRITE
    @(negedge clk); reset = 1'b0; opcode = 6'b101011; mem_ready = 1'b0; #1;
    check("abort_decode_state", {28'd0, state}, 32'd1);
    @(negedge clk); #1;
    check("abort_addr_state", {28'd0, state}, 32'd2);
    @(negedge clk); #1;
    check("abort_mw_state", {28'd0, state}, 32'd5);
    check("abort_mw_strobe", {31'd0, mem_write}, 32'd1);
    @(negedge clk); reset = 1'b1; mem_ready = 1'b1; #1;
    check("abort_rst_state", {28'd0, state}, 32'd5);
    check("abort_rst_ctrl", {12'd0, act_cw}, {12'd0, RST});
    @(negedge clk); reset = 1'b0; #1;
    check("abort_after_state", {28'd0, state}, 32'd0);
    check("abort_after_count", retired_count, 32'd0);
    check("abort_after_ctrl", {12'd0, act_cw}, {12'd0, F_RDY});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
